// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide engine.
// Provides op encodings, FSM state codes, the iteration count and a small
// op-classification helper used by the top module.
package muldiv_pkg;

  localparam int ITER_CNT = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // FSM state codes (IDLE/CALC/FIX)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // MULT/MULTU/DIV/DIVU all have op[2]=0
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Execute-stage bus between the pipeline and the HI/LO mul/div engine.
//   master (pipeline): drives start/op/opA/opB/flush, observes results.
//   slave  (engine)  : consumes commands, drives busy/done/div_zero/hi/lo.
interface hilo_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, opA, opB, flush,
                  input  busy, done, div_zero, hi, lo);
  modport slave  (input  start, op, opA, opB, flush,
                  output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the mul/div sequence.
//   div_mode : 0 = shift-add multiply, 1 = restoring divide
//   acc      : 2*WIDTH accumulator ({hi_part, lo_part})
//   operand  : multiplicand magnitude (mul) or divisor magnitude (div)
//   acc_nxt  : accumulator after this iteration
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               div_mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [WIDTH:0]   sum;     // upper half + multiplicand, carry kept
  logic [WIDTH:0]   rem_sh;  // remainder shifted left, may need WIDTH+1 bits
  logic [WIDTH-1:0] diff;
  logic             borrow;

  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    borrow = (rem_sh < {1'b0, operand});
    // When no borrow the true difference is below the divisor, so the low
    // WIDTH bits of a modular subtract are exact.
    diff   = rem_sh[WIDTH-1:0] - operand;
    if (div_mode)
      acc_nxt = {(borrow ? rem_sh[WIDTH-1:0] : diff), acc[WIDTH-2:0], ~borrow};
    else if (acc[0])
      acc_nxt = {sum, acc[WIDTH-1:1]};
    else
      acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide engine owning the architectural HI/LO registers.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of hilo_muldiv_unit_if (command in, HI/LO out)
// Mul/div run 32 iterations on magnitudes, then a FIX cycle applies signs and
// commits. Divide-by-zero skips straight to FIX. MTHI/MTLO write in IDLE.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hilo_muldiv_unit_if.slave    bus
);

  localparam int CW = $clog2(ITER_CNT);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;     // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_q;     // signA ^ signB: negate product / quotient
  logic               neg_r;     // signA: negate remainder
  logic               dz_pend;   // current op is a divide by zero
  logic [2*WIDTH-1:0] acc_nxt;

  logic               sgn_op, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  always_comb begin
    sgn_op   = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    sa       = sgn_op & bus.opA[WIDTH-1];
    sb       = sgn_op & bus.opB[WIDTH-1];
    // Unsigned WIDTH-bit magnitude: |most negative| is exact here.
    mag_a    = sa ? -bus.opA : bus.opA;
    mag_b    = sb ? -bus.opB : bus.opB;
    prod_fix = neg_q ? -acc : acc;
    q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (is_div),
    .acc      (acc),
    .operand  (mcand),
    .acc_nxt  (acc_nxt)
  );

  assign bus.busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      acc          <= '0;
      mcand        <= '0;
      is_div       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      dz_pend      <= 1'b0;
      bus.hi       <= '0;
      bus.lo       <= '0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // start beats a same-cycle flush: the flush targets an older op
          if (bus.start) begin
            if (is_muldiv(bus.op)) begin
              bus.div_zero <= 1'b0;
              is_div       <= bus.op[1];
              neg_q        <= sa ^ sb;
              neg_r        <= sa;
              cnt          <= CW'(ITER_CNT - 1);
              if (bus.op[1] && bus.opB == '0) begin
                // FIX commits acc verbatim with signs suppressed
                acc     <= {bus.opA, {WIDTH{1'b1}}};
                neg_q   <= 1'b0;
                neg_r   <= 1'b0;
                dz_pend <= 1'b1;
                state   <= ST_FIX;
              end else begin
                acc     <= bus.op[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
                mcand   <= bus.op[1] ? mag_b : mag_a;
                dz_pend <= 1'b0;
                state   <= ST_CALC;
              end
            end else if (bus.op == OP_MTHI) begin
              bus.hi <= bus.opA;
            end else if (bus.op == OP_MTLO) begin
              bus.lo <= bus.opA;
            end
          end
        end
        ST_CALC: begin
          if (bus.flush) begin
            state <= ST_IDLE;
          end else begin
            acc <= acc_nxt;
            if (cnt == '0) state <= ST_FIX;
            else           cnt   <= cnt - 1'b1;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          if (!bus.flush) begin
            if (is_div) begin
              bus.hi <= r_fix;
              bus.lo <= q_fix;
            end else begin
              {bus.hi, bus.lo} <= prod_fix;
            end
            bus.done <= 1'b1;
            if (dz_pend) bus.div_zero <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
